seq_mult: RTL
=============

# seq_mult

Parametrised sequential shift-add multiplier with a valid/ready handshake on both sides. It replaces the fixed 4x4 combinational full-adder array wherever area matters more than latency. The block trades throughput for one `WIDTH+1`-bit adder and retires one multiplier bit per clock. An optional two's-complement signed mode is selectable per operation.

## Interface

Parameters:
- `WIDTH`, default 4: operand width in bits; legal range 2..32.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block idle, can accept operands.
- `x`  input  WIDTH  multiplicand.
- `y`  input  WIDTH  multiplier.
- `signed_mode`  input  1  treat `x`/`y` as two's complement; exists only with `SEQ_MULT_SIGNED_EN`.
- `out_valid`  output  1  product valid.
- `out_ready`  input  1  consumer takes product.
- `p`  output  2*WIDTH  product.

## Operation

- States:
  - IDLE: `in_ready`=1.
  - BUSY: computing.
  - DONE: `out_valid`=1.
- IDLE -> BUSY when `in_valid`&&`in_ready` (the accept edge):
  - latch `x` into the multiplicand register and `y` into the low half of the accumulator;
  - clear the high half (`WIDTH+1` bits, including the guard bit);
  - clear the bit counter;
  - latch `signed_mode` if configured.
- BUSY, each cycle:
  - if accumulator LSB=1, high half += multiplicand, at `WIDTH+1` bits;
  - shift the whole accumulator right by 1;
  - counter += 1.
- Unsigned mode: the multiplicand is zero-extended, the add carry goes into the guard bit, and the shift is logical.
- Signed mode, on the final step (counter = `WIDTH-1`): subtract the multiplicand instead of adding it.
  - The multiplicand is sign-extended to `WIDTH+1` bits.
  - Every shift is arithmetic, replicating the guard bit.
- BUSY -> DONE when the counter reaches `WIDTH-1` and that step completes. `p` = low `2*WIDTH` bits of the accumulator.
- DONE: `p` and `out_valid` are held stable until `out_ready`=1. Then -> IDLE and `out_valid` drops on the same edge.
- `in_ready`=0 in BUSY and DONE; `in_valid` is ignored there. An operand is never lost and never double-accepted.
- No early termination: a zero operand still takes the full `WIDTH` cycles.
- Reset (`rst_n`=0 at an edge), in any state including mid-BUSY:
  - state=IDLE;
  - `in_ready`=1, `out_valid`=0, `p`=0;
  - counter and accumulator cleared;
  - the in-flight operation is discarded.

## Timing

- Accept edge E0. BUSY covers edges E1..E`WIDTH`. `out_valid`=1 after edge E`WIDTH`, so latency is `WIDTH` cycles.
- If `out_ready`=1 in the first DONE cycle, the block is back in IDLE after E`WIDTH+1`. The next accept can be no earlier than E`WIDTH+2`, so throughput is 1 product per `WIDTH+2` cycles.
- `in_ready` and `out_valid` are registered state decodes with no combinational path from `in_valid` or `out_ready`. `p` is driven directly from the accumulator register.

## Configuration

- `SEQ_MULT_SIGNED_EN` defined:
  - the `signed_mode` port exists;
  - the multiplicand register and adder are extended for sign handling;
  - the final step subtracts when `signed_mode` was latched high.
- Not defined:
  - no `signed_mode` port;
  - unsigned-only datapath;
  - final step is a plain add; all shifts are logical.

## Structure

- Package `seq_mult_pkg` holds:
  - the state enum `seq_mult_state_t` (IDLE, BUSY, DONE), encoded as 2 bits;
  - the localparam function for counter width, `$clog2(WIDTH)`.
- Sub-module `seq_mult_addsub`:
  - a `WIDTH+1`-bit combinational add/subtract;
  - inputs `a`, `b`, `sub`; output `s`.
  - It is the only arithmetic in the block.
- The top level holds the FSM, counter, accumulator and handshake.

## Test plan

- `WIDTH`=4, unsigned: x=2, y=4 -> `p`=0x08, `out_valid` exactly 4 edges after accept.
- `WIDTH`=4, unsigned: x=15, y=3 -> `p`=0x2D; x=15, y=15 -> `p`=0xE1.
- `WIDTH`=8, unsigned: x=255, y=255 -> `p`=0xFE01.
- Backpressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 and new operands applied -> `p` stable, `in_ready`=0, no new accept. Then `out_ready`=1 -> IDLE next edge; the next operand is accepted.
- Reset mid-operation: drive `rst_n`=0 for one edge at BUSY step 2 -> `in_ready`=1, `out_valid`=0, `p`=0. A fresh x=3, y=5 then yields 0x0F.
- With `SEQ_MULT_SIGNED_EN`, `WIDTH`=4, signed:
  - x=-8, y=7 -> `p`=0xC8 (-56);
  - x=-8, y=-8 -> `p`=0x40;
  - x=-1, y=-1 -> `p`=0x01.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the seq_mult shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_mult_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_addsub.sv
// WIDTH+1-bit combinational add/subtract; the only arithmetic in seq_mult.
module seq_mult_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] s
);

  assign s = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Define SEQ_MULT_SIGNED_EN to add the per-operation two's-complement signed_mode port.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready and out_valid are pure decodes of the state register.
  seq_mult_state_t  state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc;
  logic             sgn;

  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic             last;
  logic             fill;
  logic [2*WIDTH:0] acc_next;

  assign last      = (cnt == CW'(WIDTH - 1));
  assign mcand_ext = {sgn & mcand[WIDTH-1], mcand};
  assign addend    = acc[0] ? mcand_ext : '0;

  seq_mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (acc[2*WIDTH:WIDTH]),
    .b   (addend),
    .sub (sgn & last),
    .s   (sum)
  );

  // Signed shifts replicate the guard bit; unsigned shifts bring in zero.
  assign fill     = sgn & sum[WIDTH];
  assign acc_next = {fill, sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      sgn   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= x;
            acc   <= {{(WIDTH+1){1'b0}}, y};
            cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sgn   <= signed_mode;
`else
            sgn   <= 1'b0;
`endif
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign p         = acc[2*WIDTH-1:0];

endmodule
